lii_out_arbiter: RTL and testbench

Shares one LII physical output channel among N logical kernel output streams. It sits between the HLS kernel stream ports and the LII phy output, in place of a one-to-one output pack when NOUT > Q. Arbitration is round-robin with message-granular grants, and a per-grant beat cap bounds starvation. Every phy beat is tagged with this tile's source ID and the destination ID of the granted stream.

---
 rtl/lii_out_arbiter.sv | 157 +++++++++++++++
 tb/tb_lii_out_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lii_out_arbiter
// Description : Round-robin, message-granular arbiter that shares one LII phy
//               output channel among N kernel streams, with a per-grant beat cap.
// Revision    : 1.0 - initial release
// ============================================================================
module lii_out_arbiter #(
    parameter int               N       = 4,
    parameter int               PW      = 1024,
    parameter logic [7:0]       SRC_ID  = 8'h00,
    parameter logic [N*8-1:0]   DST_MAP = {N{8'h00}},
    parameter int               BURST   = 16
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [N*PW-1:0]     s_tdata,
    input  logic [N-1:0]        s_tvalid,
    input  logic [N-1:0]        s_tlast,
    output logic [N-1:0]        s_tready,
    output logic [PW-1:0]       lii_out_tdata,
    output logic                lii_out_tvalid,
    input  logic                lii_out_tready,
    output logic [7:0]          lii_out_src,
    output logic [7:0]          lii_out_dst,
    output logic                busy
);

    localparam int              GW         = (N > 1) ? $clog2(N) : 1;
    localparam int              CW         = $clog2(BURST + 1);
    localparam logic [GW-1:0]   c_last_rst = GW'(N - 1);
    localparam logic [GW:0]     c_n        = (GW+1)'(N);
    localparam logic [CW-1:0]   c_burst    = CW'(BURST);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [GW-1:0]  r_g, w_g_nxt;
    logic [GW-1:0]  r_last, w_last_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_tvalid;
    logic [PW-1:0]  r_tdata;
    logic [7:0]     r_dst;

    logic [GW-1:0]  w_pick, w_idx;
    logic [GW:0]    w_sum;
    logic [PW-1:0]  w_sel_data;
    logic [7:0]     w_sel_dst;
    logic           w_sel_valid, w_sel_last;
    logic           w_out_free, w_accept, w_release;

    // Scan downward so the smallest offset from last+1 is the final winner.
    always_comb begin
        w_pick = r_last;
        w_sum  = '0;
        w_idx  = '0;
        for (int i = N; i >= 1; i--) begin
            w_sum = {1'b0, r_last} + (GW+1)'(i);
            w_idx = (w_sum >= c_n) ? GW'(w_sum - c_n) : GW'(w_sum);
            if (s_tvalid[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_dst   = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_g == GW'(i)) begin
                w_sel_data  = s_tdata[i*PW +: PW];
                w_sel_dst   = DST_MAP[i*8 +: 8];
                w_sel_valid = s_tvalid[i];
                w_sel_last  = s_tlast[i];
            end
        end
    end

    assign w_out_free = !r_tvalid || lii_out_tready;
    assign w_accept   = (r_state == GRANT) && w_sel_valid && w_out_free;
    assign w_release  = w_accept && (w_sel_last || (r_cnt + CW'(1) == c_burst));

    always_comb begin
        s_tready = '0;
        for (int i = 0; i < N; i++) begin
            s_tready[i] = (r_state == GRANT) && w_out_free && (r_g == GW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|s_tvalid) begin
                    w_g_nxt     = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if (w_release) begin
                    w_last_nxt  = r_g;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_last  <= c_last_rst;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Output register may drain and reload on the same edge.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_dst    <= '0;
        end else if (w_accept) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_sel_data;
            r_dst    <= w_sel_dst;
        end else if (lii_out_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign lii_out_tdata  = r_tdata;
    assign lii_out_tvalid = r_tvalid;
    assign lii_out_dst    = r_dst;
    assign lii_out_src    = SRC_ID;
    assign busy           = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_lii_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lii_out_arbiter
// Description : Self-checking bench: per-stream source queues, scoreboard of
//               expected phy beats, table of arbitration vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lii_out_arbiter;

    localparam int             N       = 4;
    localparam int             PW      = 32;
    localparam int             BURST   = 4;
    localparam logic [7:0]     SRC_ID  = 8'hA5;
    localparam logic [N*8-1:0] DST_MAP = 32'h3325_1201;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
        logic [7:0]    dst;
    } beat_t;

    typedef struct {
        logic [N-1:0] mask;
        int           len;
        int           exp_first;
    } vec_t;

    logic            aclk = 1'b0;
    logic            arstn = 1'b0;
    logic [N*PW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [PW-1:0]   lii_out_tdata;
    logic            lii_out_tvalid;
    logic            lii_out_tready;
    logic [7:0]      lii_out_src;
    logic [7:0]      lii_out_dst;
    logic            busy;

    beat_t src_q[N][$];
    beat_t mir_q[N][$];
    beat_t sb_q[$];
    int    stamp_q[$];
    int    msg_id[N];
    logic [7:0] dst_tab[N];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[7];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    lii_out_arbiter #(
        .N(N), .PW(PW), .SRC_ID(SRC_ID), .DST_MAP(DST_MAP), .BURST(BURST)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid),
        .lii_out_tready(lii_out_tready), .lii_out_src(lii_out_src),
        .lii_out_dst(lii_out_dst), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*PW +: PW]  = src_q[i][0].data;
                s_tlast[i]           = src_q[i][0].last;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*PW +: PW]  = '0;
                s_tlast[i]           = 1'b0;
            end
        end
    endtask

    // Source driver and phy-side scoreboard monitor.
    initial begin
        logic [N-1:0] fire;
        logic         ofire;
        beat_t        e;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge aclk);
            fire  = s_tvalid & s_tready;
            ofire = lii_out_tvalid && lii_out_tready;
            if (ofire) begin
                stamp_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h dst=%h, expected no beat", lii_out_tdata, lii_out_dst);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_data", 64'(lii_out_tdata), 64'(e.data));
                    check("beat_dst", 64'(lii_out_dst), 64'(e.dst));
                    check("beat_src", 64'(lii_out_src), 64'(SRC_ID));
                end
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            drive();
        end
    end

    task automatic push_msg(input int s, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {8'(s), 8'(msg_id[s]), 16'(k)};
            b.last = (k == len - 1);
            b.dst  = dst_tab[s];
            src_q[s].push_back(b);
            mir_q[s].push_back(b);
        end
        msg_id[s]++;
    endtask

    task automatic exp_take(input int s, input int k);
        for (int j = 0; j < k; j++) begin
            if (mir_q[s].size() > 0) sb_q.push_back(mir_q[s].pop_front());
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    function automatic bit pending();
        bit p;
        p = lii_out_tvalid || (sb_q.size() != 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL drain_%s: got %0d beats outstanding after %0d cycles, expected 0", name, sb_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #3;
        arstn = 1'b0;
        #1;
        check("rst_tvalid", 64'(lii_out_tvalid), 64'd0);
        check("rst_tdata", 64'(lii_out_tdata), 64'd0);
        check("rst_dst", 64'(lii_out_dst), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_src", 64'(lii_out_src), 64'(SRC_ID));
        @(negedge aclk);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            mir_q[i].delete();
        end
        sb_q.delete();
        stamp_q.delete();
        lii_out_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        arstn = 1'b1;
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int n;
        dst_tab = '{8'h01, 8'h12, 8'h25, 8'h33};
        for (int i = 0; i < N; i++) msg_id[i] = 0;
        lii_out_tready = 1'b1;
        vecs[0] = '{4'b0001, 2, 0};
        vecs[1] = '{4'b0100, 1, 2};
        vecs[2] = '{4'b1000, 3, 3};
        vecs[3] = '{4'b1010, 1, 1};
        vecs[4] = '{4'b1100, 2, 2};
        vecs[5] = '{4'b1111, 1, 0};
        vecs[6] = '{4'b0110, 4, 1};

        // Single stream: stream 2, 3 beats, latency and busy timing.
        do_reset();
        push_msg(2, 3);
        exp_take(2, 3);
        step();
        @(negedge aclk);
        check("s1_c0_tready", 64'(s_tready), 64'd0);
        check("s1_c0_busy", 64'(busy), 64'd0);
        step();
        @(negedge aclk);
        check("s1_c1_tready", 64'(s_tready), 64'b0100);
        check("s1_c1_tvalid", 64'(lii_out_tvalid), 64'd0);
        step();
        @(negedge aclk);
        check("s1_c2_tvalid", 64'(lii_out_tvalid), 64'd1);
        check("s1_c2_dst", 64'(lii_out_dst), 64'h25);
        step();
        @(negedge aclk);
        check("s1_c3_busy", 64'(busy), 64'd1);
        step();
        @(negedge aclk);
        check("s1_c4_tvalid", 64'(lii_out_tvalid), 64'd1);
        check("s1_c4_busy", 64'(busy), 64'd0);
        step();
        wait_drain("single");

        // Table: first winner after reset, then ascending round-robin.
        foreach (vecs[v]) begin
            do_reset();
            for (int s = 0; s < N; s++) begin
                if (vecs[v].mask[s]) begin
                    push_msg(s, vecs[v].len);
                    exp_take(s, vecs[v].len);
                end
            end
            step();
            @(negedge aclk);
            check("vec_c0_tready", 64'(s_tready), 64'd0);
            step();
            @(negedge aclk);
            check("vec_c1_tready", 64'(s_tready), 64'(4'b0001 << vecs[v].exp_first));
            check("vec_c1_busy", 64'(busy), 64'd1);
            step();
            @(negedge aclk);
            check("vec_c2_tvalid", 64'(lii_out_tvalid), 64'd1);
            check("vec_c2_dst", 64'(lii_out_dst), 64'(dst_tab[vecs[v].exp_first]));
            step();
            wait_drain("vec");
        end

        // Round-robin fairness with one bubble per release.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_msg(0, 1);
            push_msg(1, 1);
            push_msg(3, 1);
        end
        for (int r = 0; r < 2; r++) begin
            exp_take(0, 1);
            exp_take(1, 1);
            exp_take(3, 1);
        end
        wait_drain("rr");
        check("rr_beats", 64'(stamp_q.size()), 64'd6);
        for (int i = 1; i < stamp_q.size(); i++) begin
            check("rr_spacing", 64'(stamp_q[i] - stamp_q[i-1]), 64'd2);
        end

        // Burst cap: stream 1 ten beats against three 1-beat stream 0 messages.
        do_reset();
        for (int r = 0; r < 3; r++) push_msg(0, 1);
        push_msg(1, 10);
        exp_take(0, 1);
        exp_take(1, 4);
        exp_take(0, 1);
        exp_take(1, 4);
        exp_take(0, 1);
        exp_take(1, 2);
        wait_drain("burst");

        // tlast coincides with the BURST-th beat.
        do_reset();
        push_msg(2, 4);
        push_msg(2, 1);
        push_msg(3, 4);
        exp_take(2, 4);
        exp_take(3, 4);
        exp_take(2, 1);
        wait_drain("last_cap");

        // Backpressure: tready 1,0,0,1 starting at the first output beat.
        do_reset();
        m = msg_id[0];
        push_msg(0, 4);
        exp_take(0, 4);
        step();
        step();
        step();
        @(negedge aclk);
        check("bp_c2_tvalid", 64'(lii_out_tvalid), 64'd1);
        step();
        lii_out_tready = 1'b0;
        @(negedge aclk);
        check("bp_c3_tready", 64'(s_tready), 64'd0);
        check("bp_c3_data", 64'(lii_out_tdata), 64'({8'h00, 8'(m), 16'd1}));
        step();
        @(negedge aclk);
        check("bp_c4_tready", 64'(s_tready), 64'd0);
        check("bp_c4_data", 64'(lii_out_tdata), 64'({8'h00, 8'(m), 16'd1}));
        check("bp_c4_dst", 64'(lii_out_dst), 64'h01);
        check("bp_c4_tvalid", 64'(lii_out_tvalid), 64'd1);
        step();
        lii_out_tready = 1'b1;
        @(negedge aclk);
        check("bp_c5_tready", 64'(s_tready), 64'b0001);
        step();
        wait_drain("bp");

        // Reset while a beat is held in the output register.
        do_reset();
        push_msg(1, 3);
        exp_take(1, 3);
        lii_out_tready = 1'b0;
        n = 0;
        while (!lii_out_tvalid && n < 20) begin
            step();
            n++;
        end
        check("mid_tvalid", 64'(lii_out_tvalid), 64'd1);
        check("mid_busy", 64'(busy), 64'd1);
        do_reset();
        push_msg(1, 1);
        push_msg(0, 1);
        exp_take(0, 1);
        exp_take(1, 1);
        step();
        step();
        @(negedge aclk);
        check("mid_after_tready", 64'(s_tready), 64'b0001);
        step();
        wait_drain("mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
